// File: rtl/voice_allocator.sv
// Note-event voice allocator for the FM synth envelope bank.
// Assigns note-on/off events to voices, steals voices when the pool is exhausted.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS  = 7,
  parameter int VEL_BITS   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic                             ev_on,
  input  logic [NOTE_BITS-1:0]             ev_note,
  input  logic [VEL_BITS-1:0]              ev_vel,
  input  logic                             panic,
  input  logic [NUM_VOICES-1:0]            voice_avail,
  output logic [NUM_VOICES-1:0]            voice_en,
  output logic [NUM_VOICES*NOTE_BITS-1:0]  voice_note,
  output logic [NUM_VOICES*VEL_BITS-1:0]   voice_vel,
  output logic [$clog2(NUM_VOICES):0]      active_count
);
  localparam int IDX_BITS = $clog2(NUM_VOICES);
  localparam int CNT_BITS = IDX_BITS + 1;

  typedef enum logic [1:0] {V_FREE, V_HELD, V_RELEASING} voice_state_t;
  typedef enum logic [1:0] {S_WAIT, S_SEARCH, S_COMMIT} fsm_state_t;

  fsm_state_t           r_fsm, w_fsmNext;
  voice_state_t         r_vstate     [NUM_VOICES];
  voice_state_t         w_vstateNext [NUM_VOICES];
  logic [NOTE_BITS-1:0] r_note       [NUM_VOICES];
  logic [NOTE_BITS-1:0] w_noteNext   [NUM_VOICES];
  logic [VEL_BITS-1:0]  r_vel        [NUM_VOICES];
  logic [VEL_BITS-1:0]  w_velNext    [NUM_VOICES];
  logic [IDX_BITS-1:0]  r_stealPtr, w_stealPtrNext;
  logic [CNT_BITS-1:0]  r_activeCount, w_activeCount;

  logic                 r_evOn;
  logic [NOTE_BITS-1:0] r_evNote;
  logic [VEL_BITS-1:0]  r_evVel;

  logic [NUM_VOICES-1:0] r_matchHeld, r_matchRel, w_matchHeld, w_matchRel;
  logic                  r_freeFound, r_relFound, w_freeFound, w_relFound;
  logic [IDX_BITS-1:0]   r_freeIdx, r_relIdx, w_freeIdx, w_relIdx;
  logic [IDX_BITS-1:0]   w_relMatchIdx;
  logic                  w_effOff;

  assign ev_ready = (r_fsm == S_WAIT) && !panic;

  // Search over the current voice table; descending loops leave the lowest index.
  always_comb begin
    w_matchHeld = '0;
    w_matchRel  = '0;
    w_freeFound = 1'b0;
    w_freeIdx   = '0;
    w_relFound  = 1'b0;
    w_relIdx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_note[i] == r_evNote) begin
        w_matchHeld[i] = (r_vstate[i] == V_HELD);
        w_matchRel[i]  = (r_vstate[i] == V_RELEASING);
      end
      if (r_vstate[i] == V_FREE) begin
        w_freeFound = 1'b1;
        w_freeIdx   = IDX_BITS'(i);
      end
      if (r_vstate[i] == V_RELEASING) begin
        w_relFound = 1'b1;
        w_relIdx   = IDX_BITS'(i);
      end
    end
  end

  always_comb begin
    w_relMatchIdx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_matchRel[i]) w_relMatchIdx = IDX_BITS'(i);
    end
  end

  // Next voice table: avail frees first, a commit then overrides, panic overrides both.
  always_comb begin
    w_fsmNext      = r_fsm;
    w_stealPtrNext = r_stealPtr;
    w_vstateNext   = r_vstate;
    w_noteNext     = r_note;
    w_velNext      = r_vel;
    w_effOff       = !r_evOn || (r_evVel == '0);

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (voice_avail[i] && (r_vstate[i] == V_RELEASING)) w_vstateNext[i] = V_FREE;
    end

    case (r_fsm)
      S_WAIT:   if (ev_valid && ev_ready) w_fsmNext = S_SEARCH;
      S_SEARCH: w_fsmNext = S_COMMIT;
      S_COMMIT: begin
        w_fsmNext = S_WAIT;
        if (!panic) begin
          if (w_effOff) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_matchHeld[i]) w_vstateNext[i] = V_RELEASING;
            end
          end else if (|r_matchHeld) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_matchHeld[i]) w_velNext[i] = r_evVel;
            end
          end else if (|r_matchRel) begin
            w_vstateNext[w_relMatchIdx] = V_HELD;
            w_velNext[w_relMatchIdx]    = r_evVel;
          end else if (r_freeFound) begin
            w_vstateNext[r_freeIdx] = V_HELD;
            w_noteNext[r_freeIdx]   = r_evNote;
            w_velNext[r_freeIdx]    = r_evVel;
          end else if (r_relFound) begin
            w_vstateNext[r_relIdx] = V_HELD;
            w_noteNext[r_relIdx]   = r_evNote;
            w_velNext[r_relIdx]    = r_evVel;
          end else begin
            w_vstateNext[r_stealPtr] = V_HELD;
            w_noteNext[r_stealPtr]   = r_evNote;
            w_velNext[r_stealPtr]    = r_evVel;
            w_stealPtrNext           = r_stealPtr + IDX_BITS'(1);
          end
        end
      end
      default:  w_fsmNext = S_WAIT;
    endcase

    if (panic) begin
      w_fsmNext = S_WAIT;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (r_vstate[i] == V_HELD) w_vstateNext[i] = V_RELEASING;
      end
    end
  end

  always_comb begin
    w_activeCount = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_vstateNext[i] != V_FREE) w_activeCount = w_activeCount + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm         <= S_WAIT;
      r_stealPtr    <= '0;
      r_activeCount <= '0;
      r_evOn        <= 1'b0;
      r_evNote      <= '0;
      r_evVel       <= '0;
      r_matchHeld   <= '0;
      r_matchRel    <= '0;
      r_freeFound   <= 1'b0;
      r_freeIdx     <= '0;
      r_relFound    <= 1'b0;
      r_relIdx      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vstate[i] <= V_FREE;
        r_note[i]   <= '0;
        r_vel[i]    <= '0;
      end
    end else begin
      r_fsm         <= w_fsmNext;
      r_stealPtr    <= w_stealPtrNext;
      r_activeCount <= w_activeCount;
      r_vstate      <= w_vstateNext;
      r_note        <= w_noteNext;
      r_vel         <= w_velNext;
      if ((r_fsm == S_WAIT) && ev_valid && ev_ready) begin
        r_evOn   <= ev_on;
        r_evNote <= ev_note;
        r_evVel  <= ev_vel;
      end
      if (r_fsm == S_SEARCH) begin
        r_matchHeld <= w_matchHeld;
        r_matchRel  <= w_matchRel;
        r_freeFound <= w_freeFound;
        r_freeIdx   <= w_freeIdx;
        r_relFound  <= w_relFound;
        r_relIdx    <= w_relIdx;
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_en[g]                           = (r_vstate[g] == V_HELD);
    assign voice_note[g*NOTE_BITS +: NOTE_BITS]  = r_note[g];
    assign voice_vel[g*VEL_BITS +: VEL_BITS]     = r_vel[g];
  end

  assign active_count = r_activeCount;

endmodule
